// File: rtl/move_log_unscrambler.sv
// rtl/move_log_unscrambler.sv - LIFO move log that replays logged grid moves newest-first with add_n inverted; optional MOVE_LOG_UNDO_ONE_EN adds single-step undo_one
module move_log_unscrambler #(
    parameter int DEPTH    = 64,
    parameter int ADDR_W   = 6,
    parameter int PACE_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_valid,
    input  logic              move_nrow,
    input  logic [3:0]        move_sel,
    input  logic              move_addn,
    input  logic              undo_start,
    input  logic              undo_abort,
`ifdef MOVE_LOG_UNDO_ONE_EN
    input  logic              undo_one,
`endif
    output logic              replay_fire,
    output logic              replay_nrow,
    output logic [3:0]        replay_sel,
    output logic              replay_addn,
    output logic              busy,
    output logic [ADDR_W:0]   depth,
    output logic              overflow
);

    localparam int                CNT_W    = $clog2(PACE_DIV);
    localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  PACE_LD  = CNT_W'(PACE_DIV - 2);
    localparam logic [CNT_W-1:0]  PACE_END = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_FIRE,
        S_WAIT
    } state_t;

    state_t             state;
    state_t             state_nx;

    // Entry layout: {nrow, addn, index[1:0]}
    logic [3:0]         log_mem [DEPTH];
    logic [ADDR_W-1:0]  wptr;
    logic [ADDR_W-1:0]  rptr;
    logic [3:0]         rd_entry;
    logic [CNT_W-1:0]   pace_cnt;
    logic               one_shot;

    logic               sel_ok;
    logic [1:0]         sel_idx;
    logic               push_ok;
    logic               has_entries;
    logic               start_all;
    logic               start_one;

    // Encode the one-hot line select; anything else is not a loggable move
    always_comb begin
        sel_ok  = 1'b1;
        sel_idx = 2'd0;
        case (move_sel)
            4'b0001: sel_idx = 2'd0;
            4'b0010: sel_idx = 2'd1;
            4'b0100: sel_idx = 2'd2;
            4'b1000: sel_idx = 2'd3;
            default: sel_ok  = 1'b0;
        endcase
    end

    // Only moves seen while idle are logged, so replay fires never re-enter the log
    assign push_ok     = (state == S_IDLE) && move_valid && sel_ok;
    // A push in the same cycle as undo_start counts, so the replay includes it
    assign has_entries = (depth != '0) || push_ok;
    assign start_all   = undo_start && !undo_abort && has_entries;
`ifdef MOVE_LOG_UNDO_ONE_EN
    assign start_one   = undo_one && !undo_start && !undo_abort && has_entries;
`else
    assign start_one   = 1'b0;
`endif

    assign rptr        = wptr - 1'b1;
    assign rd_entry    = log_mem[rptr];
    assign replay_fire = (state == S_FIRE);
    assign busy        = (state != S_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; abort returns to IDLE from any replay state
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (start_all || start_one) begin
                    state_nx = S_READ;
                end
            end
            S_READ: begin
                state_nx = undo_abort ? S_IDLE : S_FIRE;
            end
            S_FIRE: begin
                state_nx = undo_abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                if (undo_abort) begin
                    state_nx = S_IDLE;
                end else if (pace_cnt == PACE_END) begin
                    // Count steps 1 -> 0 on this edge: pacing interval complete
                    state_nx = ((depth != '0) && !one_shot) ? S_READ : S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Log storage write; no reset needed since depth defines what is valid
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            log_mem[wptr] <= {move_nrow, move_addn, sel_idx};
        end
    end

    // Write pointer, fill level and overflow flag; pushes and pops never coincide
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            depth    <= '0;
            overflow <= 1'b0;
        end else if (push_ok) begin
            wptr <= wptr + 1'b1;
            if (depth == DEPTH_V) begin
                overflow <= 1'b1;
            end else begin
                depth <= depth + 1'b1;
            end
        end else if (state == S_FIRE) begin
            wptr  <= wptr - 1'b1;
            depth <= depth - 1'b1;
            // Emptying the log through replay puts the grid back at the logged baseline
            if (depth == (ADDR_W + 1)'(1)) begin
                overflow <= 1'b0;
            end
        end
    end

    // Replayed move register: loaded from the log in READ, zero whenever idle
    always_ff @(posedge clk) begin
        if (reset || (state_nx == S_IDLE)) begin
            replay_nrow <= 1'b0;
            replay_sel  <= 4'b0000;
            replay_addn <= 1'b0;
        end else if (state == S_READ) begin
            replay_nrow <= rd_entry[3];
            replay_addn <= ~rd_entry[2];
            replay_sel  <= 4'b0001 << rd_entry[1:0];
        end
    end

    // Pacing counter between fire pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            pace_cnt <= '0;
        end else if (state == S_FIRE) begin
            pace_cnt <= PACE_LD;
        end else if (state == S_WAIT) begin
            pace_cnt <= pace_cnt - 1'b1;
        end
    end

    // Remember whether the current replay is a single-step undo
    always_ff @(posedge clk) begin
        if (reset) begin
            one_shot <= 1'b0;
        end else if (state == S_IDLE) begin
            one_shot <= start_one;
        end
    end

endmodule

// File: tb/tb_move_log_unscrambler.sv
// tb/tb_move_log_unscrambler.sv - directed self-checking bench for move_log_unscrambler
module tb_move_log_unscrambler;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_valid;
    logic       move_nrow;
    logic [3:0] move_sel;
    logic       move_addn;
    logic       undo_start;
    logic       undo_abort;
`ifdef MOVE_LOG_UNDO_ONE_EN
    logic       undo_one;
`endif
    logic       replay_fire;
    logic       replay_nrow;
    logic [3:0] replay_sel;
    logic       replay_addn;
    logic       busy;
    logic [6:0] depth;
    logic       overflow;

    int         n_cmp = 0;
    int         n_bad = 0;
    int         fire_cyc[$];
    logic [5:0] fire_mv[$];
    int         busy_fall;

    move_log_unscrambler #(.DEPTH(64), .ADDR_W(6), .PACE_DIV(16)) dut (
        .clk(clk), .reset(reset),
        .move_valid(move_valid), .move_nrow(move_nrow), .move_sel(move_sel), .move_addn(move_addn),
        .undo_start(undo_start), .undo_abort(undo_abort),
`ifdef MOVE_LOG_UNDO_ONE_EN
        .undo_one(undo_one),
`endif
        .replay_fire(replay_fire), .replay_nrow(replay_nrow), .replay_sel(replay_sel),
        .replay_addn(replay_addn), .busy(busy), .depth(depth), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move k uses pattern e = k mod 16 as {nrow, addn, index}
    function automatic logic [5:0] exp_k(input int k);
        logic [3:0] e;
        e = 4'(k % 16);
        return {e[3], ~e[2], 4'b0001 << e[1:0]};
    endfunction

    task automatic push(input logic nrow, input logic [3:0] sel, input logic addn);
        move_valid = 1'b1;
        move_nrow  = nrow;
        move_sel   = sel;
        move_addn  = addn;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic push_k(input int k);
        logic [3:0] e;
        e = 4'(k % 16);
        push(e[3], 4'b0001 << e[1:0], e[2]);
    endtask

    function automatic int get_cyc(input int i);
        return (i < fire_cyc.size()) ? fire_cyc[i] : -1;
    endfunction

    function automatic int get_mv(input int i);
        return (i < fire_mv.size()) ? int'(fire_mv[i]) : -1;
    endfunction

    // Cycle 0 is the cycle the start pulse is driven; records fires and busy fall
    task automatic run(input int max_cyc, input int abort_at, input int inject_at,
                       input int reset_at, input bit one);
        fire_cyc.delete();
        fire_mv.delete();
        busy_fall = -1;
        for (int c = 0; c < max_cyc; c++) begin
`ifdef MOVE_LOG_UNDO_ONE_EN
            undo_one   = one && (c == 0);
`endif
            undo_start = !one && (c == 0);
            undo_abort = (c == abort_at);
            reset      = (c == reset_at);
            move_valid = (c == inject_at);
            move_nrow  = 1'b0;
            move_sel   = 4'b0100;
            move_addn  = 1'b0;
            tick();
            if (replay_fire) begin
                fire_cyc.push_back(c + 1);
                fire_mv.push_back({replay_nrow, replay_addn, replay_sel});
            end
            if (!busy) begin
                busy_fall = c + 1;
                break;
            end
        end
        undo_start = 1'b0;
        undo_abort = 1'b0;
        reset      = 1'b0;
        move_valid = 1'b0;
`ifdef MOVE_LOG_UNDO_ONE_EN
        undo_one   = 1'b0;
`endif
    endtask

    initial begin
        int quiet;
        reset = 1'b1; move_valid = 1'b0; move_nrow = 1'b0; move_sel = 4'b0; move_addn = 1'b0;
        undo_start = 1'b0; undo_abort = 1'b0;
`ifdef MOVE_LOG_UNDO_ONE_EN
        undo_one = 1'b0;
`endif
        repeat (3) tick();
        reset = 1'b0;
        check_eq("rst_fire", int'(replay_fire), 0);
        check_eq("rst_sel", int'(replay_sel), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_depth", int'(depth), 0);
        check_eq("rst_ovf", int'(overflow), 0);

        // Basic three-move replay
        push(1'b0, 4'b0010, 1'b1);
        push(1'b1, 4'b1000, 1'b1);
        push(1'b0, 4'b0001, 1'b0);
        check_eq("t1_depth_pre", int'(depth), 3);
        run(100, -1, -1, -1, 1'b0);
        check_eq("t1_nfire", fire_cyc.size(), 3);
        check_eq("t1_cyc0", get_cyc(0), 2);
        check_eq("t1_cyc1", get_cyc(1), 18);
        check_eq("t1_cyc2", get_cyc(2), 34);
        check_eq("t1_mv0", get_mv(0), 6'b0_1_0001);
        check_eq("t1_mv1", get_mv(1), 6'b1_0_1000);
        check_eq("t1_mv2", get_mv(2), 6'b0_0_0010);
        check_eq("t1_busy_fall", busy_fall, 49);
        check_eq("t1_depth_post", int'(depth), 0);
        check_eq("t1_idle_sel", int'(replay_sel), 0);

        // Overflow: 70 pushes into 64 entries
        for (int k = 1; k <= 70; k++) push_k(k);
        check_eq("t2_depth", int'(depth), 64);
        check_eq("t2_ovf", int'(overflow), 1);
        run(1100, -1, -1, -1, 1'b0);
        check_eq("t2_nfire", fire_cyc.size(), 64);
        for (int i = 0; i < 64; i++) check_eq($sformatf("t2_mv%0d", i), get_mv(i), int'(exp_k(70 - i)));
        check_eq("t2_busy_fall", busy_fall, 1025);
        check_eq("t2_ovf_post", int'(overflow), 0);
        check_eq("t2_depth_post", int'(depth), 0);

        // Dropped moves: non-one-hot selects and moves while busy
        push(1'b1, 4'b0100, 1'b0);
        push(1'b0, 4'b0110, 1'b0);
        push(1'b0, 4'b0000, 1'b0);
        check_eq("t3_depth_bad_sel", int'(depth), 1);
        run(60, -1, 5, -1, 1'b0);
        check_eq("t3_nfire", fire_cyc.size(), 1);
        check_eq("t3_mv0", get_mv(0), 6'b1_1_0100);
        check_eq("t3_depth_busy_push", int'(depth), 0);

        // Push and undo_start together: the pushed move is replayed
        run(60, -1, 0, -1, 1'b0);
        check_eq("t3_simul_nfire", fire_cyc.size(), 1);
        check_eq("t3_simul_mv", get_mv(0), 6'b0_1_0100);
        check_eq("t3_simul_fall", busy_fall, 17);

        // Abort mid-replay, abort beats start, then resume
        for (int k = 1; k <= 5; k++) push_k(k);
        run(100, 20, -1, -1, 1'b0);
        check_eq("t4_nfire", fire_cyc.size(), 2);
        check_eq("t4_cyc1", get_cyc(1), 18);
        check_eq("t4_mv0", get_mv(0), int'(exp_k(5)));
        check_eq("t4_busy_fall", busy_fall, 21);
        check_eq("t4_depth", int'(depth), 3);
        run(20, 0, -1, -1, 1'b0);
        check_eq("t4_abort_start_fall", busy_fall, 1);
        check_eq("t4_abort_start_depth", int'(depth), 3);
        run(100, -1, -1, -1, 1'b0);
        check_eq("t4_resume_nfire", fire_cyc.size(), 3);
        check_eq("t4_resume_mv0", get_mv(0), int'(exp_k(3)));
        check_eq("t4_resume_mv2", get_mv(2), int'(exp_k(1)));
        check_eq("t4_resume_depth", int'(depth), 0);

        // Empty-log start is ignored; reset mid-replay
        run(20, -1, -1, -1, 1'b0);
        check_eq("t5_empty_fall", busy_fall, 1);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (busy || replay_fire) quiet++;
        end
        check_eq("t5_empty_quiet", quiet, 0);
        for (int k = 1; k <= 3; k++) push_k(k);
        run(60, -1, -1, 10, 1'b0);
        check_eq("t5_rst_fall", busy_fall, 11);
        check_eq("t5_rst_nfire", fire_cyc.size(), 1);
        check_eq("t5_rst_fire", int'(replay_fire), 0);
        check_eq("t5_rst_nrow", int'(replay_nrow), 0);
        check_eq("t5_rst_sel", int'(replay_sel), 0);
        check_eq("t5_rst_addn", int'(replay_addn), 0);
        check_eq("t5_rst_depth", int'(depth), 0);

`ifdef MOVE_LOG_UNDO_ONE_EN
        // Single-step undo
        push_k(6);
        push_k(7);
        run(60, -1, -1, -1, 1'b1);
        check_eq("t6_nfire", fire_cyc.size(), 1);
        check_eq("t6_cyc0", get_cyc(0), 2);
        check_eq("t6_mv0", get_mv(0), int'(exp_k(7)));
        check_eq("t6_busy_fall", busy_fall, 17);
        check_eq("t6_depth", int'(depth), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/move_log_unscrambler.md
Name: move_log_unscrambler

Overview:
- LIFO log of every move applied to the 4x4 cell grid. A move is a row or column select, its one-hot line and the add_n direction.
- On request, the log is popped newest-first. Each popped move is re-issued with add_n inverted, which undoes scramble or user moves.
- Sits between the scramble/user move mux and the x-cell array.
- The top level muxes replay_* onto the fire/row/col/add_n lines while busy is high.

Parameters:
- DEPTH, 64, log entries (power of two, >=4).
- ADDR_W, 6, log2(DEPTH).
- PACE_DIV, 16, cycles between consecutive replay_fire pulses (>=3).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high; clears log, counters, FSM.
- move_valid  in  1  one-cycle pulse: a move was applied this cycle.
- move_nrow  in  1  0 = row move, 1 = column move.
- move_sel  in  4  one-hot row/column line of the move.
- move_addn  in  1  add_n value used by the move.
- undo_start  in  1  pulse: begin replaying entire log.
- undo_abort  in  1  pulse: stop replay, keep remaining entries.
- replay_fire  out  1  one-cycle fire pulse for the replayed move.
- replay_nrow  out  1  row/column flag of the replayed move.
- replay_sel  out  4  one-hot line of the replayed move.
- replay_addn  out  1  inverted stored add_n.
- busy  out  1  high from the cycle after undo_start until return to IDLE.
- depth  out  ADDR_W+1  entries currently held (0..DEPTH).
- overflow  out  1  sticky: at least one oldest entry was overwritten.

Behaviour:
- Reset values: replay_fire=0, replay_nrow=0, replay_sel=0000, replay_addn=0, busy=0, depth=0, overflow=0. FSM=IDLE, write pointer=0.
- Entry format: 4 bits = {nrow, addn, index[1:0]}. The index is encoded from one-hot move_sel (0001->0 ... 1000->3).
- Push happens in IDLE only, on move_valid with move_sel exactly one-hot:
  - Write at wptr, wptr<=wptr+1 (mod DEPTH).
  - depth<=depth+1, saturating at DEPTH.
  - A push while depth==DEPTH overwrites the oldest entry and sets overflow.
- Dropped without effect: move_valid with a non-one-hot move_sel (0000 or multi-hot), and any move_valid while busy. Replay's own fires are not re-logged.
- Simultaneous move_valid and undo_start in IDLE: the push happens first and the replay includes that move.
- undo_start with depth==0: ignored, busy stays 0.
- FSM states:
  - IDLE: on undo_start with depth>0 -> READ; busy<=1.
  - READ (1 cycle): rptr=wptr-1; synchronous log read registered onto replay_nrow/sel/addn.
  - FIRE (1 cycle): replay_fire=1; wptr<=wptr-1; depth<=depth-1; pace counter loaded to PACE_DIV-2.
  - WAIT: counter decrements. At 0: -> READ if depth>0, else -> IDLE with busy<=0.
- Latency:
  - undo_start in cycle 0 -> replay_fire in cycle 2.
  - Consecutive replay_fire pulses are exactly PACE_DIV cycles apart.
  - The last fire is followed by busy falling PACE_DIV-1 cycles later.
- replay_nrow/sel/addn stay stable from READ through the end of WAIT. They are 0 in IDLE.
- undo_abort in any non-IDLE state:
  - Next state is IDLE, busy<=0.
  - A pop already committed in FIRE is kept; no further pops.
  - undo_abort and undo_start together in IDLE: abort wins, no start.
- overflow clears only on reset, or when depth reaches 0 through replay (the log is empty, so the grid is back at the logged baseline).
- Reset mid-replay: all outputs return to reset values next cycle and the log is emptied.

Optional Feature:
- MOVE_LOG_UNDO_ONE_EN.
- Defined: adds input port undo_one (1 bit). A pulse in IDLE with depth>0 runs READ->FIRE->WAIT for one entry only, then returns to IDLE. Priority: undo_abort > undo_start > undo_one.
- Undefined: port absent; only whole-log replay exists.

Test Plan:
1. Reset, then push 3 moves: (row,0010,add), (col,1000,add), (row,0001,sub); undo_start.
   - depth=3 before start.
   - Fires at cycles 2, 18, 34 replay in this order: (nrow=0,sel=0001,addn=1), (nrow=1,sel=1000,addn=0), (nrow=0,sel=0010,addn=0).
   - busy falls at cycle 49; depth=0.
2. Push 70 moves with DEPTH=64.
   - depth=64, overflow=1.
   - Replay yields moves 70 down to 7, then overflow=0.
3. move_valid with move_sel=0110, then 0000 -> depth unchanged. move_valid while busy -> not logged.
4. 5 moves logged, undo_start, undo_abort at cycle 20 -> exactly 2 fires, busy=0 at cycle 21, depth=3; a second undo_start replays the remaining 3.
5. undo_start with depth=0 -> busy and replay_fire stay 0. reset asserted at cycle 10 of a replay -> all outputs 0 and depth=0 at cycle 11.
6. (MOVE_LOG_UNDO_ONE_EN) 2 moves logged, undo_one -> one fire at cycle 2, depth=1, busy=0 after PACE_DIV-1 further cycles.
